// File: rtl/b1to4_tdm_demuxer.sv
// Receive side of a 4-slot TDM link: splits a sync-aligned sample stream into
// four registered channel outputs, tracking frame alignment with a HUNT/LOCKED FSM.
module b1to4_tdm_demuxer #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   x,
  input  logic           x_valid,
  input  logic           sync,
  output logic [4*W-1:0] z3_z0,
  output logic [3:0]     upd,
  output logic           frame,
  output logic           locked,
  output logic           err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     slot_q, slot_d;
  logic [4*W-1:0] z_q, z_d;
  logic [3:0]     upd_q, upd_d;
  logic           frame_q, frame_d;
  logic           err_q, err_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; without this a latch is inferred.
    state_d = state_q;
    slot_d  = slot_q;
    z_d     = z_q;
    upd_d   = 4'b0000;
    frame_d = 1'b0;
    err_d   = 1'b0;

    if (x_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            z_d[0 +: W] = x;
            upd_d       = 4'b0001;
            slot_d      = 2'd1;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync on a non-zero slot is an early sync: flag it, then realign.
            err_d       = (slot_q != 2'd0);
            z_d[0 +: W] = x;
            upd_d       = 4'b0001;
            slot_d      = 2'd1;
          end else if (slot_q != 2'd0) begin
            z_d[slot_q*W +: W] = x;
            upd_d              = 4'b0001 << slot_q;
            slot_d             = slot_q + 2'd1;
            frame_d            = (slot_q == 2'd3);
          end else begin
            err_d   = 1'b1;
            slot_d  = 2'd0;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      z_q     <= '0;
      upd_q   <= 4'b0000;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      z_q     <= z_d;
      upd_q   <= upd_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign z3_z0  = z_q;
  assign upd    = upd_q;
  assign frame  = frame_q;
  assign err    = err_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_b1to4_tdm_demuxer.sv
// Scoreboarded bench: a frame-buffer reference model predicts every strobe/error
// event, and a monitor compares them against the DUT as they appear.
module tb_b1to4_tdm_demuxer;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [W-1:0]   x;
  logic           x_valid;
  logic           sync;
  logic [4*W-1:0] z3_z0;
  logic [3:0]     upd;
  logic           frame;
  logic           locked;
  logic           err;

  b1to4_tdm_demuxer #(.W(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .x      (x),
    .x_valid(x_valid),
    .sync   (sync),
    .z3_z0  (z3_z0),
    .upd    (upd),
    .frame  (frame),
    .locked (locked),
    .err    (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]     upd;
    logic           frame;
    logic           err;
    logic           locked;
    logic [4*W-1:0] z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the link is either hunting, or holds the samples of the
  // frame in progress; the next expected slot is simply how many it holds.
  bit           m_hunt;
  logic [W-1:0] m_ch[4];
  logic [W-1:0] m_cur[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [4*W-1:0] m_z();
    return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
  endfunction

  task automatic push(input logic [3:0] u, input logic f, input logic e, input logic l);
    exp_t t;
    t.upd = u; t.frame = f; t.err = e; t.locked = l; t.z = m_z();
    sb.push_back(t);
  endtask

  task automatic model_reset();
    m_hunt = 1'b1;
    m_cur.delete();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
    int k;
    if (!v) return;
    if (s) begin
      push_sync(d);
    end else if (!m_hunt) begin
      k = m_cur.size();
      if (k == 0) begin
        m_hunt = 1'b1;
        push(4'b0000, 1'b0, 1'b1, 1'b0);
      end else begin
        m_ch[k] = d;
        m_cur.push_back(d);
        if (k == 3) m_cur.delete();
        push(4'(1 << k), (k == 3), 1'b0, 1'b1);
      end
    end
  endtask

  task automatic push_sync(input logic [W-1:0] d);
    logic early;
    early = !m_hunt && (m_cur.size() != 0);
    m_cur.delete();
    m_cur.push_back(d);
    m_ch[0] = d;
    m_hunt  = 1'b0;
    push(4'b0001, 1'b0, early, 1'b1);
  endtask

  task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
    x_valid = v; sync = s; x = d;
    @(posedge clock);
    #1;
    model_step(v, s, d);
    x_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1; x_valid = 1'b0; sync = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
    check("reset_z", 64'(z3_z0), 64'(0));
    check("reset_outs", 64'({upd, frame, locked, err}), 64'(0));
  endtask

  // Monitor: every cycle with a strobe or error pulse must match the next
  // predicted event.
  initial begin
    exp_t t;
    forever begin
      @(negedge clock);
      if (upd != 4'b0000 || frame || err) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 64'({upd, frame, err}), 64'(0));
        end else begin
          t = sb.pop_front();
          check("upd",    64'(upd),    64'(t.upd));
          check("frame",  64'(frame),  64'(t.frame));
          check("err",    64'(err),    64'(t.err));
          check("locked", 64'(locked), 64'(t.locked));
          check("z3_z0",  64'(z3_z0),  64'(t.z));
        end
      end
    end
  end

  initial begin
    bit s;
    int r;
    reset = 1'b0; x = '0; x_valid = 1'b0; sync = 1'b0;
    model_reset();
    do_reset();

    // 1: clean frame
    drive(1, 1, 8'h11); drive(1, 0, 8'h22); drive(1, 0, 8'h33); drive(1, 0, 8'h44);
    check("t1_z", 64'(z3_z0), 64'(32'h4433_2211));
    check("t1_frame", 64'({frame, upd, locked}), 64'({1'b1, 4'b1000, 1'b1}));
    gap(2);

    // 2: hunting ignores unsynced samples
    do_reset();
    drive(1, 0, 8'hAA); drive(1, 0, 8'hBB);
    check("t2_hunt", 64'({locked, upd, z3_z0}), 64'(0));
    drive(1, 1, 8'hCC);
    check("t2_lock", 64'({locked, upd, z3_z0}), 64'({1'b1, 4'b0001, 32'h0000_00CC}));
    gap(1);

    // 3: early sync resyncs without frame pulse, next frame completes
    drive(1, 1, 8'h01); drive(1, 0, 8'h02); drive(1, 1, 8'h03);
    check("t3_err", 64'({err, frame, upd}), 64'({1'b1, 1'b0, 4'b0001}));
    drive(1, 0, 8'h04); drive(1, 0, 8'h05); drive(1, 0, 8'h06);
    check("t3_z", 64'(z3_z0), 64'(32'h0605_0403));
    check("t3_frame", 64'(frame), 64'(1));

    // 4: missing sync drops lock, next sync relocks
    drive(1, 0, 8'h77);
    check("t4_err", 64'({err, upd, locked}), 64'({1'b1, 4'b0000, 1'b0}));
    drive(1, 1, 8'h88);
    check("t4_relock", 64'(locked), 64'(1));
    drive(1, 0, 8'h99); drive(1, 0, 8'h9A); drive(1, 0, 8'h9B);

    // 5: gapped frame
    do_reset();
    drive(1, 1, 8'h11); gap(3); drive(1, 0, 8'h22); gap(3);
    drive(1, 0, 8'h33); gap(3); drive(1, 0, 8'h44);
    check("t5_z", 64'(z3_z0), 64'(32'h4433_2211));
    check("t5_frame", 64'(frame), 64'(1));
    gap(3);
    check("t5_quiet", 64'({upd, frame, err}), 64'(0));

    // 6: reset mid-frame
    drive(1, 1, 8'h5A); drive(1, 0, 8'h5B); drive(1, 0, 8'h5C);
    do_reset();
    drive(1, 0, 8'h61); drive(1, 0, 8'h62);
    check("t6_hunt", 64'({locked, z3_z0}), 64'(0));
    drive(1, 1, 8'h63);
    check("t6_relock", 64'(locked), 64'(1));

    // Randomized traffic, mostly well-formed with occasional alignment faults.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) s = 1'($urandom);
        else s = (m_cur.size() == 0);
        drive(r < 75, s, W'($urandom));
      end
    end

    gap(3);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
